// File: rtl/time_keep_ctrl_if.sv
// Event inputs and time/status outputs of the timekeeping controller.
interface time_keep_ctrl_if;
  logic       tick_1hz;
  logic       key_mode;
  logic       key_inc;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       blink;
  logic       hour_pulse;

  modport master (
    output tick_1hz, key_mode, key_inc,
    input  hour, min, sec, mode, blink, hour_pulse
  );

  modport slave (
    input  tick_1hz, key_mode, key_inc,
    output hour, min, sec, mode, blink, hour_pulse
  );
endinterface

// File: rtl/time_keep_ctrl.sv
// HH:MM:SS timekeeper with RUN/SET_H/SET_M/SET_S edit FSM; outputs registered, latency 1.
// No backpressure: every tick and key pulse is consumed on the cycle it arrives.
module time_keep_ctrl #(
  parameter int H_MOD = 24,
  parameter int M_MOD = 60,
  parameter int S_MOD = 60
) (
  input  logic clk,
  input  logic rst_n,
  time_keep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_e;

  localparam logic [4:0] H_MAX = 5'(H_MOD - 1);
  localparam logic [5:0] M_MAX = 6'(M_MOD - 1);
  localparam logic [5:0] S_MAX = 6'(S_MOD - 1);

  mode_e      mode_q, mode_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       blink_q, blink_d;
  logic       hour_pulse_q, hour_pulse_d;

  logic       sec_wrap, min_wrap, hour_wrap;
  logic [4:0] hour_inc;
  logic [5:0] min_inc;
  logic [5:0] sec_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next-state: key_mode cycles through the four modes, otherwise hold
  always_comb begin
    mode_d = mode_q;
    if (bus.key_mode) begin
      unique case (mode_q)
        RUN:     mode_d = SET_H;
        SET_H:   mode_d = SET_M;
        SET_M:   mode_d = SET_S;
        SET_S:   mode_d = RUN;
        default: mode_d = RUN;
      endcase
    end
  end

  // Per-field wrapping increments, shared by RUN carry chain and SET edits
  always_comb begin
    sec_wrap  = (sec_q == S_MAX);
    min_wrap  = (min_q == M_MAX);
    hour_wrap = (hour_q == H_MAX);
    sec_inc   = sec_wrap  ? 6'd0 : sec_q + 6'd1;
    min_inc   = min_wrap  ? 6'd0 : min_q + 6'd1;
    hour_inc  = hour_wrap ? 5'd0 : hour_q + 5'd1;
  end

  // Output/datapath logic, governed by the mode held before the edge
  always_comb begin
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    blink_d      = blink_q;
    hour_pulse_d = 1'b0;

    if (mode_q == RUN) begin
      // key_inc is ignored here; a simultaneous key_mode still lets time advance
      blink_d = bus.key_mode;
      if (bus.tick_1hz) begin
        sec_d = sec_inc;
        if (sec_wrap) begin
          min_d = min_inc;
          if (min_wrap) begin
            hour_d       = hour_inc;
            hour_pulse_d = 1'b1;
          end
        end
      end
    end else if (bus.key_mode) begin
      // Leaving SET_S returns to RUN (blank off); any other step enters a SET mode
      blink_d = (mode_q != SET_S);
    end else if (bus.key_inc) begin
      blink_d = 1'b1;
      unique case (mode_q)
        SET_H:   hour_d = hour_inc;
        SET_M:   min_d  = min_inc;
        SET_S:   sec_d  = sec_inc;
        default: ;
      endcase
    end else if (bus.tick_1hz) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      blink_q      <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      blink_q      <= blink_d;
      hour_pulse_q <= hour_pulse_d;
    end
  end

  assign bus.hour       = hour_q;
  assign bus.min        = min_q;
  assign bus.sec        = sec_q;
  assign bus.mode       = mode_q;
  assign bus.blink      = blink_q;
  assign bus.hour_pulse = hour_pulse_q;

endmodule

// File: tb/tb_time_keep_ctrl.sv
// Directed bench for time_keep_ctrl: reset, setting, rollover, field wrap, collisions, blink.
module tb_time_keep_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  time_keep_ctrl_if bus ();

  time_keep_ctrl #(.H_MOD(24), .M_MOD(60), .S_MOD(60)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply pulses for one cycle; returns at the next falling edge with outputs updated
  task automatic step(input bit m, input bit i, input bit t);
    bus.key_mode = m;
    bus.key_inc  = i;
    bus.tick_1hz = t;
    @(negedge clk);
    bus.key_mode = 1'b0;
    bus.key_inc  = 1'b0;
    bus.tick_1hz = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, int'(bus.hour), h);
    chk({tag, ".min"},  int'(bus.min),  m);
    chk({tag, ".sec"},  int'(bus.sec),  s);
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b1;
    bus.key_mode = 1'b0;
    bus.key_inc  = 1'b0;
    bus.tick_1hz = 1'b0;
    #3 rst_n = 1'b0;
    @(negedge clk);

    // 1: reset holds everything at zero despite activity
    step(1, 1, 1);
    step(0, 1, 1);
    step(1, 0, 1);
    chk_time("rst", 0, 0, 0);
    chk("rst.mode",  int'(bus.mode), 0);
    chk("rst.blink", int'(bus.blink), 0);
    chk("rst.hp",    int'(bus.hour_pulse), 0);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (3) step(0, 0, 1);
    chk_time("run3", 0, 0, 3);
    step(0, 1, 0);
    chk_time("run_inc_ignored", 0, 0, 3);

    // 2: set 23:59:59
    step(1, 0, 0);
    chk("seth.mode",  int'(bus.mode), 1);
    chk("seth.blink", int'(bus.blink), 1);
    repeat (23) step(0, 1, 0);
    chk_time("seth23", 23, 0, 3);
    step(0, 0, 1);
    chk_time("seth_frozen", 23, 0, 3);
    chk("seth.blink_tog", int'(bus.blink), 0);
    step(1, 0, 0);
    chk("setm.mode",  int'(bus.mode), 2);
    chk("setm.blink", int'(bus.blink), 1);
    repeat (59) step(0, 1, 0);
    step(1, 0, 0);
    chk("sets.mode", int'(bus.mode), 3);
    chk_time("sets_keep", 23, 59, 3);
    repeat (56) step(0, 1, 0);
    step(1, 0, 0);
    chk("run.mode",  int'(bus.mode), 0);
    chk("run.blink", int'(bus.blink), 0);
    chk_time("set_done", 23, 59, 59);

    // 3: full rollover with one-cycle hour_pulse
    step(0, 0, 1);
    chk_time("roll", 0, 0, 0);
    chk("roll.hp", int'(bus.hour_pulse), 1);
    step(0, 0, 0);
    chk("roll.hp_off", int'(bus.hour_pulse), 0);

    // 4: field wraps without carry
    step(1, 0, 0);
    repeat (23) step(0, 1, 0);
    step(1, 0, 0);
    repeat (59) step(0, 1, 0);
    chk_time("wrapm_pre", 23, 59, 0);
    step(0, 1, 0);
    chk_time("wrapm", 23, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("wraph.mode", int'(bus.mode), 1);
    step(0, 1, 0);
    chk_time("wraph", 0, 0, 0);
    step(0, 0, 1);
    chk("tick_blink", int'(bus.blink), 0);
    step(0, 1, 1);
    chk_time("inc_tick", 1, 0, 0);
    chk("inc_tick.blink", int'(bus.blink), 1);
    repeat (3) step(1, 0, 0);
    chk("back_run", int'(bus.mode), 0);

    // 5: collisions
    step(1, 1, 0);
    chk("mk_run.mode", int'(bus.mode), 1);
    chk_time("mk_run", 1, 0, 0);
    repeat (23) step(0, 1, 0);
    step(1, 1, 0);
    chk("mk_seth.mode", int'(bus.mode), 2);
    chk_time("mk_seth", 0, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 1, 0);
    step(1, 0, 1);
    chk("mt_sets.mode", int'(bus.mode), 0);
    chk_time("mt_sets", 0, 0, 5);
    step(1, 0, 1);
    chk("mt_run.mode", int'(bus.mode), 1);
    chk_time("mt_run", 0, 0, 6);
    chk("mt_run.blink", int'(bus.blink), 1);

    // 6: blink toggling in SET_M, inc forcing, async reset mid-edit
    step(1, 0, 0);
    chk("b.enter", int'(bus.blink), 1);
    step(0, 0, 1); chk("b.t1", int'(bus.blink), 0);
    step(0, 0, 1); chk("b.t2", int'(bus.blink), 1);
    step(0, 0, 1); chk("b.t3", int'(bus.blink), 0);
    step(0, 0, 1); chk("b.t4", int'(bus.blink), 1);
    step(0, 0, 1); chk("b.t5", int'(bus.blink), 0);
    step(0, 1, 0);
    chk("b.inc", int'(bus.blink), 1);
    chk_time("b.inc_t", 0, 1, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.mode",  int'(bus.mode), 0);
    chk("arst.blink", int'(bus.blink), 0);
    chk_time("arst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1);
    chk_time("post_rst", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
